// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: digit-serial long division driving one shared narrow div stage.
// Define DIV_SEQ_ROUND_EN for round-to-nearest on non-zero divisors.
module div_seq_ctrl #(
  parameter int NUMER_W = 8,
  parameter int DENOM_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUMER_W-1:0]   numer,
  input  logic [DENOM_W-1:0]   denom,
  output logic [2*DENOM_W-1:0] stg_numer,
  output logic [DENOM_W-1:0]   stg_denom,
  input  logic [2*DENOM_W-1:0] stg_quot,
  input  logic [DENOM_W-1:0]   stg_rem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMER_W-1:0]   quot,
  output logic [DENOM_W-1:0]   rem,
  output logic                 div_zero
);
  localparam int STEPS = NUMER_W / DENOM_W;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic               init_q;
  logic [NUMER_W-1:0] num_q;
  logic [DENOM_W-1:0] den_q;
  logic [DENOM_W-1:0] rr_q;
  logic [NUMER_W-1:0] q_q;
  logic [CW-1:0]      step_q;
  logic [NUMER_W-1:0] quot_q;
  logic [DENOM_W-1:0] rem_q;
  logic               dz_q;

  logic               accept;
  logic               calc;
  logic               last;
  logic [NUMER_W-1:0] q_nx;
  logic [NUMER_W-1:0] quot_fin;
  logic               unused_hi;

  // rem_reg < denom keeps the stage quotient inside DENOM_W bits
  assign unused_hi = ^stg_quot[2*DENOM_W-1:DENOM_W];

  assign accept = in_valid && in_ready;
  assign calc   = (state_q == S_CALC);
  assign last   = (step_q == CW'(STEPS - 1));
  assign q_nx   = (q_q << DENOM_W)
                | NUMER_W'(stg_quot[DENOM_W-1:0]);

`ifdef DIV_SEQ_ROUND_EN
  logic rnd_up;
  assign rnd_up = ({1'b0, stg_rem} << 1) >= {1'b0, den_q};
  assign quot_fin = (rnd_up && (q_nx != '1))
                  ? q_nx + NUMER_W'(1) : q_nx;
`else
  assign quot_fin = q_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (denom == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    stg_numer = '0;
    stg_denom = '0;
    unique case (1'b1)
      (state_q == S_IDLE): in_ready = init_q;
      (state_q == S_CALC): begin
        stg_numer = {rr_q, num_q[NUMER_W-1 -: DENOM_W]};
        stg_denom = den_q;
      end
      (state_q == S_DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      den_q  <= '0;
      rr_q   <= '0;
      q_q    <= '0;
      step_q <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      num_q  <= numer;
      den_q  <= denom;
      rr_q   <= '0;
      q_q    <= '0;
      step_q <= '0;
      if (denom == '0) begin
        quot_q <= '1;
        rem_q  <= '0;
        dz_q   <= 1'b1;
      end else begin
        dz_q   <= 1'b0;
      end
    end else if (calc) begin
      rr_q   <= stg_rem;
      q_q    <= q_nx;
      num_q  <= num_q << DENOM_W;
      step_q <= step_q + CW'(1);
      if (last) begin
        quot_q <= quot_fin;
        rem_q  <= stg_rem;
      end
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed + random requests against an arithmetic model.
// Honours DIV_SEQ_ROUND_EN the same way as the design build.
module tb_div_seq_ctrl;
  localparam int NW = 8;
  localparam int DW = 4;
  localparam int STEPS = NW / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] numer = '0;
  logic [DW-1:0] denom = '0;
  logic [2*DW-1:0] stg_numer;
  logic [DW-1:0] stg_denom;
  logic [2*DW-1:0] stg_quot;
  logic [DW-1:0] stg_rem;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NW-1:0] quot;
  logic [DW-1:0] rem;
  logic          div_zero;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl #(.NUMER_W(NW), .DENOM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .numer(numer), .denom(denom),
    .stg_numer(stg_numer), .stg_denom(stg_denom),
    .stg_quot(stg_quot), .stg_rem(stg_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // shared narrow divider stage
  always_comb begin
    stg_quot = '0;
    stg_rem  = '0;
    if (stg_denom != '0) begin
      stg_quot = stg_numer / 8'(stg_denom);
      stg_rem  = 4'(stg_numer % 8'(stg_denom));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input int n, input int d, output logic [NW-1:0] q,
                         output logic [DW-1:0] r, output logic z);
    int qi, ri;
    if (d == 0) begin
      q = '1; r = '0; z = 1'b1;
    end else begin
      qi = n / d;
      ri = n % d;
`ifdef DIV_SEQ_ROUND_EN
      if (2 * ri >= d && qi < 255) qi++;
`endif
      q = NW'(qi); r = DW'(ri); z = 1'b0;
    end
  endtask

  // operand at digit step s: remainder of consumed prefix, then next digit
  function automatic logic [2*DW-1:0] exp_stg(input int n, input int d,
                                             input int s);
    int hi, dig;
    hi  = n >> (NW - DW * s);
    dig = (n >> (NW - DW * (s + 1))) & ((1 << DW) - 1);
    return 8'(((hi % d) << DW) | dig);
  endfunction

  task automatic run(input int n, input int d, input int bp);
    logic [NW-1:0] eq;
    logic [DW-1:0] er;
    logic ez;
    int w;
    ref_div(n, d, eq, er, ez);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready", in_ready, 1);
    numer = NW'(n);
    denom = DW'(d);
    in_valid = 1'b1;
    out_ready = (bp == 0);
    @(negedge clk);
    in_valid = 1'b0;
    numer = NW'($urandom);
    denom = DW'($urandom);
    if (d != 0) begin
      for (int s = 0; s < STEPS; s++) begin
        chk("stg_numer", stg_numer, exp_stg(n, d, s));
        chk("stg_denom", stg_denom, d);
        chk("busy_valid", out_valid, 0);
        chk("busy_ready", in_ready, 0);
        @(negedge clk);
      end
    end
    chk("out_valid", out_valid, 1);
    chk("quot", quot, eq);
    chk("rem", rem, er);
    chk("div_zero", div_zero, ez);
    chk("stg_idle", stg_numer, 0);
    for (int c = 0; c < bp; c++) begin
      in_valid = 1'b1;
      numer = NW'($urandom);
      denom = DW'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_quot", quot, eq);
      chk("bp_rem", rem, er);
      chk("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_stg", stg_numer, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", in_ready, 0);
    @(negedge clk);
    chk("init_ready", in_ready, 1);

    run(100, 5, 0);
    run(200, 4, 0);
    run(7, 9, 0);
    run(255, 15, 0);
    run(123, 0, 0);
    run(103, 4, 0);
    run(255, 2, 0);
    run(14, 15, 0);
    run(60, 7, 10);
    run(100, 5, 0);

    // reset in CALC step 1 discards the job
    numer = 8'd200;
    denom = 4'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_stg", stg_numer, exp_stg(200, 7, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_quot", quot, 0);
    chk("mid_rst_rem", rem, 0);
    chk("mid_rst_dz", div_zero, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_stg", stg_numer, 0);
    chk("mid_rst_den", stg_denom, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
    end
    run(100, 5, 0);

    for (int i = 0; i < 30; i++) begin
      int n, d;
      n = int'($urandom_range(255, 0));
      d = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(15, 1));
      run(n, d, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
